counter_arbiter_ctrl: RTL and testbench
=======================================

Name: counter_arbiter_ctrl

Overview:
Shares one `counter` instance (down-count mode) between P_NREQ requesters, each asking for a countdown of a requested length. The block arbitrates requests, loads the counter through its write port, and enables it. It watches carry to detect expiry and returns a one-cycle done pulse to the winner. It sits between timer clients and the counter datapath, driving all counter control inputs.

Parameters:
P_NREQ, 4, number of requesters (2..16)
P_BIT, 32, counter width; must match the counter instance
P_BASE, 32, counter modulus; must match the counter instance; legal lengths are 1..P_BASE

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  P_NREQ  per-requester request level; must stay high until done or err
req_len  in  P_NREQ*P_BIT  packed lengths; requester i uses bits [i*P_BIT +: P_BIT]
gnt  out  P_NREQ  one-hot; high in LOAD and RUN for the winner
done  out  P_NREQ  one-cycle pulse to the winner on expiry
err  out  P_NREQ  one-cycle pulse when the selected length is 0 or > P_BASE
busy  out  1  high when state != IDLE
cnt_enable  out  1  to counter enable
cnt_up_dw  out  1  to counter up_dw; constant 0 (down)
cnt_wenable  out  1  to counter wenable
cnt_wcount  out  P_BIT  to counter wcount
cnt_carry  in  1  from counter carry (combinational in counter)

Behaviour:
- Reset (async, reset=1): state=IDLE, rr pointer=0, and every registered output is 0 (gnt, done, err, busy, cnt_enable, cnt_wenable, cnt_wcount). cnt_up_dw=0.
- Reset mid-operation: immediate abort with no done or err; the counter keeps its value and the next LOAD overwrites it.
- All outputs are registered, except cnt_up_dw, which is tied to 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req != 0, select winner w round-robin, searching from the rr pointer upward and wrapping. Latch w and len = req_len[w].
  - If len==0 or len>P_BASE: err[w]=1 next cycle, stay IDLE, rr pointer=w+1 mod P_NREQ.
  - Otherwise go to LOAD.
- LOAD (1 cycle): gnt[w]=1, cnt_wenable=1, cnt_wcount=len-1, cnt_enable=0. Go to RUN.
- RUN: gnt[w]=1, cnt_enable=1, cnt_wenable=0.
  - Counter goes len-1 … 0; carry is high in the cycle count==0, i.e. the len-th RUN cycle.
  - On cnt_carry=1: go to DONE. cnt_enable drops for the next cycle; the counter's wrap to P_BASE-1 is harmless.
- DONE (1 cycle): done[w]=1, gnt=0, rr pointer=w+1 mod P_NREQ. Go to IDLE.
- Latency from req first sampled in IDLE: 1 (IDLE→LOAD) + 1 LOAD + len RUN + 1 DONE. The next arbitration happens in the following IDLE cycle, so the minimum gap between grants is 1 IDLE cycle.
- Abort: if req[w] falls in LOAD or RUN, go to IDLE next cycle. gnt=0, cnt_enable=0, no done, rr pointer=w+1.
- Simultaneous req rise and fall in other channels do not affect the current grant.
- A requester that holds req after err is re-evaluated on its next turn.
- Any unknown or illegal state decodes to IDLE.

Optional Feature:
CNT_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, where the lowest index wins; the rr pointer is unused and held at 0.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both modes.

Decomposition:
- Shared package counter_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3);
  - a length-legality function (1..P_BASE);
  - a one-hot-to-index function.
- One sub-module: rr_arbiter. Inputs are req and ptr; output is a one-hot grant. It also contains the fixed-priority variant under CNT_ARB_FIXED_PRIO_EN.
- The FSM and counter-drive logic stay in counter_arbiter_ctrl.

Test Plan:
1. Single request: req=4'b0001, len=5 → gnt[0] for 6 cycles (1 LOAD + 5 RUN), cnt_wcount=4, done[0] pulse in the following cycle, busy low afterwards.
2. Round-robin: req=4'b1111 held, all len=2 → grant order 0,1,2,3,0, each done separated by exactly 5 cycles (IDLE, LOAD, RUN×2, DONE).
3. Boundaries: len=32 → 32 RUN cycles, cnt_wcount=31. len=0 and len=33 → err pulse only, no gnt, no cnt_wenable.
4. Abort: req[2] dropped at RUN cycle 3 of len=10 → gnt low, cnt_enable low next cycle, no done[2]; next requester granted afterwards.
5. Reset mid-RUN: assert reset for 1 cycle → all outputs 0 immediately; after release, req=4'b0110 grants index 1 (pointer reset to 0).
6. With CNT_ARB_FIXED_PRIO_EN, req=4'b1010 held, len=1 → index 1 granted repeatedly, index 3 never granted.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared types and helpers for the counter arbiter controller.
package counter_arb_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widest requester vector the helpers accept.
    localparam int MAX_NREQ = 16;

    // A countdown length is usable when it lies in 1..base.
    function automatic logic len_legal(input logic [63:0] len, input logic [63:0] base);
        return (len != 64'd0) && (len <= base);
    endfunction

    // Index of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/counter_arbiter_ctrl_rr_arbiter.sv
// Requester selection for the counter arbiter.
// CNT_ARB_FIXED_PRIO_EN: when defined, lowest index wins and ptr is ignored;
// otherwise round-robin search starting at ptr and wrapping.
module rr_arbiter
    import counter_arb_pkg::*;
#(
    parameter int P_NREQ = 4,
    parameter int IDX_W  = 2
) (
    input  logic [P_NREQ-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [P_NREQ-1:0] gnt
);

`ifdef CNT_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest requesting index is the last writer.
    always_comb begin
        gnt = '0;
        for (int i = P_NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end
`else
    logic found;
    int   idx;

    // Round-robin: first requester found walking up from ptr, wrapping at P_NREQ.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < P_NREQ; k++) begin
            idx = (int'(ptr) + k) % P_NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/counter_arbiter_ctrl.sv
// Shares one down-counting counter between P_NREQ timer clients.
// Arbitrates, loads the counter with len-1, runs it until carry, then pulses
// done to the winner. Build option CNT_ARB_FIXED_PRIO_EN selects fixed
// priority (lowest index wins, pointer held at 0) instead of round-robin.
module counter_arbiter_ctrl
    import counter_arb_pkg::*;
#(
    parameter int P_NREQ = 4,
    parameter int P_BIT  = 32,
    parameter int P_BASE = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [P_NREQ-1:0]       req,
    input  logic [P_NREQ*P_BIT-1:0] req_len,
    output logic [P_NREQ-1:0]       gnt,
    output logic [P_NREQ-1:0]       done,
    output logic [P_NREQ-1:0]       err,
    output logic                    busy,
    output logic                    cnt_enable,
    output logic                    cnt_up_dw,
    output logic                    cnt_wenable,
    output logic [P_BIT-1:0]        cnt_wcount,
    input  logic                    cnt_carry
);

    localparam int IDX_W = $clog2(P_NREQ);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   w;
    logic [IDX_W-1:0]   w_next;
    logic [P_NREQ-1:0]  win_oh;
    logic [P_BIT-1:0]   sel_len;

    // Pointer value that gives the requester after p the next turn.
    function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] p);
`ifdef CNT_ARB_FIXED_PRIO_EN
        return '0;
`else
        if (int'(p) == P_NREQ - 1) return '0;
        return p + IDX_W'(1);
`endif
    endfunction

    // The counter only ever counts down.
    assign cnt_up_dw = 1'b0;

    rr_arbiter #(
        .P_NREQ (P_NREQ),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (win_oh)
    );

    // Candidate winner index and its requested length.
    always_comb begin
        w_next  = IDX_W'(onehot_to_idx(MAX_NREQ'(win_oh)));
        sel_len = req_len[int'(w_next)*P_BIT +: P_BIT];
    end

    // Controller FSM with registered outputs. gnt holds the winner one-hot
    // through LOAD and RUN, so it doubles as the done vector on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            w           <= '0;
            gnt         <= '0;
            done        <= '0;
            err         <= '0;
            busy        <= 1'b0;
            cnt_enable  <= 1'b0;
            cnt_wenable <= 1'b0;
            cnt_wcount  <= '0;
        end else begin
            done        <= '0;
            err         <= '0;
            cnt_wenable <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        w <= w_next;
                        if (len_legal(64'(sel_len), 64'(P_BASE))) begin
                            state       <= LOAD;
                            gnt         <= win_oh;
                            busy        <= 1'b1;
                            cnt_wenable <= 1'b1;
                            cnt_wcount  <= sel_len - P_BIT'(1);
                            cnt_enable  <= 1'b0;
                        end else begin
                            err    <= win_oh;
                            rr_ptr <= inc_ptr(w_next);
                        end
                    end
                end
                LOAD: begin
                    if (!req[w]) begin
                        state      <= IDLE;
                        gnt        <= '0;
                        busy       <= 1'b0;
                        cnt_enable <= 1'b0;
                        rr_ptr     <= inc_ptr(w);
                    end else begin
                        state      <= RUN;
                        cnt_enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (!req[w]) begin
                        state      <= IDLE;
                        gnt        <= '0;
                        busy       <= 1'b0;
                        cnt_enable <= 1'b0;
                        rr_ptr     <= inc_ptr(w);
                    end else if (cnt_carry) begin
                        // Counter wraps to P_BASE-1 on this edge; enable drops so it parks there.
                        state      <= DONE;
                        gnt        <= '0;
                        done       <= gnt;
                        cnt_enable <= 1'b0;
                        rr_ptr     <= inc_ptr(w);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    gnt        <= '0;
                    busy       <= 1'b0;
                    cnt_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter_ctrl.sv
// Bench for counter_arbiter_ctrl with a behavioural down-counter and a
// scoreboard of expected done/err pulses.
module tb_counter_arbiter_ctrl;

    localparam int P_NREQ = 4;
    localparam int P_BIT  = 32;
    localparam int P_BASE = 32;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [P_NREQ-1:0]       req = '0;
    logic [P_NREQ*P_BIT-1:0] req_len = '0;
    logic [P_NREQ-1:0]       gnt;
    logic [P_NREQ-1:0]       done;
    logic [P_NREQ-1:0]       err;
    logic                    busy;
    logic                    cnt_enable;
    logic                    cnt_up_dw;
    logic                    cnt_wenable;
    logic [P_BIT-1:0]        cnt_wcount;
    logic                    cnt_carry;
    logic [P_BIT-1:0]        count = '0;

    always #5 clk = ~clk;

    // Counter model: load wins over enable, down-count wraps to P_BASE-1, no reset.
    always @(posedge clk) begin
        if (cnt_wenable) count <= cnt_wcount;
        else if (cnt_enable) count <= (count == '0) ? P_BIT'(P_BASE - 1) : count - P_BIT'(1);
    end
    assign cnt_carry = cnt_enable && (count == '0);

    counter_arbiter_ctrl #(
        .P_NREQ (P_NREQ),
        .P_BIT  (P_BIT),
        .P_BASE (P_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_len     (req_len),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .cnt_enable  (cnt_enable),
        .cnt_up_dw   (cnt_up_dw),
        .cnt_wenable (cnt_wenable),
        .cnt_wcount  (cnt_wcount),
        .cnt_carry   (cnt_carry)
    );

    typedef struct {
        bit         is_err;
        logic [3:0] vec;
        int         len;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         cyc = 0;
    int         run_cnt = 0;
    int         gnt_cyc = 0;
    int         wen_cnt = 0;
    int         done_count = 0;
    int         err_count = 0;
    int         last_done_cyc = 0;
    int         grant_cnt[P_NREQ];
    logic [P_BIT-1:0] ld_wcount = '0;
    exp_t       mon_e;

    initial for (int i = 0; i < P_NREQ; i++) grant_cnt[i] = 0;

    // Monitor: tracks grant/run lengths and pops the scoreboard on each pulse.
    always @(negedge clk) begin
        cyc++;
        if (cnt_wenable) begin
            ld_wcount = cnt_wcount;
            run_cnt   = 0;
            gnt_cyc   = 0;
            wen_cnt++;
            for (int i = 0; i < P_NREQ; i++) if (gnt[i]) grant_cnt[i]++;
        end
        if (gnt != '0) gnt_cyc++;
        if (gnt != '0 && cnt_enable) run_cnt++;
        if (done != '0 || err != '0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 64'({done, err}), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_err) begin
                    err_count++;
                    check("err_vec", 64'(err), 64'(mon_e.vec));
                    check("err_no_done", 64'(done), 64'(0));
                end else begin
                    done_count++;
                    last_done_cyc = cyc;
                    check("done_vec", 64'(done), 64'(mon_e.vec));
                    check("run_cycles", 64'(run_cnt), 64'(mon_e.len));
                    check("load_wcount", 64'(ld_wcount), 64'(mon_e.len - 1));
                    check("gnt_cycles", 64'(gnt_cyc), 64'(mon_e.len + 1));
                end
            end
        end
    end

    task automatic push_done(input logic [3:0] v, input int len);
        exp_t x;
        x.is_err = 1'b0; x.vec = v; x.len = len;
        sb.push_back(x);
    endtask

    task automatic push_err(input logic [3:0] v);
        exp_t x;
        x.is_err = 1'b1; x.vec = v; x.len = 0;
        sb.push_back(x);
    endtask

    task automatic set_len(input int i, input int len);
        req_len[i*P_BIT +: P_BIT] = P_BIT'(len);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, 64'(done_count >= target), 64'(1));
    endtask

    task automatic wait_err(input int target, input int budget, input string tag);
        int n = 0;
        while (err_count < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, 64'(err_count >= target), 64'(1));
    endtask

    task automatic wait_run(input int wen_target, input int run_target, input int budget, input string tag);
        int n = 0;
        while (!(wen_cnt >= wen_target && run_cnt >= run_target) && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, 64'(wen_cnt >= wen_target && run_cnt >= run_target), 64'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_cyc[5];
        int w0;
        int g0;
        logic [3:0] exp_v;

        // Reset state
        do_reset();
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cnt_enable", 64'(cnt_enable), 64'(0));
        check("rst_cnt_wenable", 64'(cnt_wenable), 64'(0));
        check("rst_cnt_wcount", 64'(cnt_wcount), 64'(0));
        check("cnt_up_dw", 64'(cnt_up_dw), 64'(0));

        // 1: single request, len 5
        set_len(0, 5);
        push_done(4'b0001, 5);
        req = 4'b0001;
        wait_done(1, 40, "t1_done_timeout");
        req = '0;
        repeat (2) @(negedge clk);
        #1;
        check("t1_busy_after", 64'(busy), 64'(0));
        check("t1_gnt_after", 64'(gnt), 64'(0));

        // 2: round-robin, all held, len 2
        do_reset();
        for (int i = 0; i < P_NREQ; i++) set_len(i, 2);
        push_done(4'b0001, 2);
        push_done(4'b0010, 2);
        push_done(4'b0100, 2);
        push_done(4'b1000, 2);
        push_done(4'b0001, 2);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(done_count + 1, 30, "t2_done_timeout");
            d_cyc[k] = last_done_cyc;
            if (k == 4) req = '0;
            if (k > 0) check("t2_done_spacing", 64'(d_cyc[k] - d_cyc[k-1]), 64'(5));
        end
        repeat (3) @(negedge clk);
        #1;

        // 3: boundary lengths
        do_reset();
        set_len(0, 32);
        push_done(4'b0001, 32);
        req = 4'b0001;
        wait_done(done_count + 1, 60, "t3_len32_timeout");
        req = '0;
        repeat (2) @(negedge clk);
        #1;
        w0 = wen_cnt;
        set_len(1, 0);
        push_err(4'b0010);
        req = 4'b0010;
        wait_err(err_count + 1, 10, "t3_len0_timeout");
        req = '0;
        set_len(2, 33);
        push_err(4'b0100);
        req = 4'b0100;
        wait_err(err_count + 1, 10, "t3_len33_timeout");
        req = '0;
        repeat (2) @(negedge clk);
        #1;
        check("t3_no_wenable_on_err", 64'(wen_cnt), 64'(w0));
        check("t3_busy_idle", 64'(busy), 64'(0));

        // 4: abort of requester 2 at RUN cycle 3; requester 3 rises mid-run
        do_reset();
        set_len(2, 10);
        set_len(3, 3);
        w0 = wen_cnt;
        g0 = grant_cnt[2];
        req = 4'b0100;
        wait_run(w0 + 1, 1, 10, "t4_run1_timeout");
        req[3] = 1'b1;
        wait_run(w0 + 1, 3, 10, "t4_run3_timeout");
        req[2] = 1'b0;
        push_done(4'b1000, 3);
        @(negedge clk); #1;
        check("t4_abort_gnt", 64'(gnt), 64'(0));
        check("t4_abort_cnt_enable", 64'(cnt_enable), 64'(0));
        check("t4_abort_busy", 64'(busy), 64'(0));
        wait_done(done_count + 1, 30, "t4_next_done_timeout");
        req = '0;
        check("t4_req2_single_grant", 64'(grant_cnt[2] - g0), 64'(1));
        repeat (2) @(negedge clk);
        #1;

        // 5: reset in the middle of RUN
        do_reset();
        set_len(0, 10);
        w0 = wen_cnt;
        req = 4'b0001;
        wait_run(w0 + 1, 4, 10, "t5_run4_timeout");
        reset = 1'b1;
        #1;
        check("t5_rst_gnt", 64'(gnt), 64'(0));
        check("t5_rst_busy", 64'(busy), 64'(0));
        check("t5_rst_cnt_enable", 64'(cnt_enable), 64'(0));
        check("t5_rst_cnt_wenable", 64'(cnt_wenable), 64'(0));
        check("t5_rst_cnt_wcount", 64'(cnt_wcount), 64'(0));
        check("t5_rst_done", 64'(done), 64'(0));
        set_len(1, 2);
        set_len(2, 2);
        req = 4'b0110;
        @(negedge clk);
        #1 reset = 1'b0;
        push_done(4'b0010, 2);
        push_done(4'b0100, 2);
        wait_done(done_count + 1, 20, "t5_first_timeout");
        wait_done(done_count + 1, 20, "t5_second_timeout");
        req = '0;
        repeat (2) @(negedge clk);
        #1;

        // 6: requesters 1 and 3 held with len 1
        do_reset();
        set_len(1, 1);
        set_len(3, 1);
        g0 = grant_cnt[3];
        for (int k = 0; k < 3; k++) begin
`ifdef CNT_ARB_FIXED_PRIO_EN
            exp_v = 4'b0010;
`else
            exp_v = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            push_done(exp_v, 1);
        end
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            wait_done(done_count + 1, 20, "t6_done_timeout");
            if (k == 2) req = '0;
        end
`ifdef CNT_ARB_FIXED_PRIO_EN
        check("t6_idx3_never", 64'(grant_cnt[3] - g0), 64'(0));
`else
        check("t6_idx3_once", 64'(grant_cnt[3] - g0), 64'(1));
`endif
        repeat (3) @(negedge clk);
        #1;

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
